// File: rtl/rl_mem_pkg.sv
// rtl/rl_mem_pkg.sv - shared types for the RAM burst reader
package rl_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } burst_state_t;

endpackage

// File: rtl/rl_skid_fifo2.sv
// rtl/rl_skid_fifo2.sv - two-entry valid/ready buffer, head entry always visible
module rl_skid_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_pop;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/rl_ram_1r1w_burst_reader.sv
// rtl/rl_ram_1r1w_burst_reader.sv - burst read engine for a 1R1W RAM with registered read
module rl_ram_1r1w_burst_reader
  import rl_mem_pkg::*;
#(
  parameter int ABITS = 10,
  parameter int DBITS = 32,
  parameter int LBITS = ABITS + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ABITS-1:0] cmd_addr,
  input  logic [LBITS-1:0] cmd_len,
  output logic [ABITS-1:0] mem_raddr,
  input  logic [DBITS-1:0] mem_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DBITS-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done
);

  burst_state_t     state, state_nxt;
  logic [ABITS-1:0] addr;
  logic [LBITS-1:0] remaining;
  logic             inflight;
  logic             inflight_last;
  logic [1:0]       occ;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DBITS:0]   head;
  logic             cmd_fire;
  logic             pop;
  logic             issue;
  logic             done_evt;
  logic [2:0]       credit;

  // The address counter is the RAM read-address register; the word read in
  // cycle C appears on mem_dout in C+1 and is pushed at the end of C+1.
  assign mem_raddr = addr;
  assign cmd_ready = (state == IDLE) && !rst;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign pop       = m_valid && m_ready;
  assign credit    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign issue     = (state == ISSUE) && (remaining != '0) && (credit < 3'd2);
  assign done_evt  = (state == DRAIN) && (state_nxt == IDLE);

  assign m_valid = !fifo_empty;
  assign m_data  = head[DBITS-1:0];
  assign m_last  = head[DBITS];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (cmd_fire) state_nxt = (cmd_len == '0) ? DRAIN : ISSUE;
      ISSUE: if (issue && (remaining == LBITS'(1))) state_nxt = DRAIN;
      // An empty pipeline in DRAIN only happens for a zero-length command.
      DRAIN: if ((pop && m_last) || (fifo_empty && !inflight)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remaining == LBITS'(1));
      done          <= done_evt;
      if (cmd_fire) begin
        addr      <= cmd_addr;
        remaining <= cmd_len;
        busy      <= 1'b1;
      end else if (issue) begin
        addr      <= addr + ABITS'(1);
        remaining <= remaining - LBITS'(1);
      end
      if (done_evt) busy <= 1'b0;
    end
  end

  rl_skid_fifo2 #(.W(DBITS + 1)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, mem_dout}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occ)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inflight && fifo_full && !pop));

endmodule

// File: tb/tb_rl_ram_1r1w_burst_reader.sv
// tb/tb_rl_ram_1r1w_burst_reader.sv - directed bench for the RAM burst reader
module tb_rl_ram_1r1w_burst_reader;

  localparam int ABITS = 4;
  localparam int DBITS = 32;
  localparam int LBITS = ABITS + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [ABITS-1:0] cmd_addr = '0;
  logic [LBITS-1:0] cmd_len = '0;
  logic [ABITS-1:0] mem_raddr;
  logic [DBITS-1:0] mem_dout = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DBITS-1:0] m_data;
  logic             m_last;
  logic             busy;
  logic             done;

  logic [DBITS-1:0] ram [16];
  int checks = 0;
  int passes = 0;

  typedef struct {
    string            name;
    logic [ABITS-1:0] addr;
    logic [LBITS-1:0] len;
    logic [15:0]      rpat;
    int               exp_beats;
    logic [DBITS-1:0] exp_first;
    logic [DBITS-1:0] exp_last;
  } vec_t;

  vec_t vecs [5];

  rl_ram_1r1w_burst_reader #(.ABITS(ABITS), .DBITS(DBITS), .LBITS(LBITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .mem_raddr (mem_raddr),
    .mem_dout  (mem_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout <= ram[mem_raddr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run_burst(input vec_t v);
    int beats = 0;
    int dones = 0;
    int first_cyc = -1;
    int first_beat_cyc = -1;
    int last_beat_cyc = -1;
    int guard = 0;
    logic stalled = 1'b0;
    logic [DBITS:0] held = '0;
    logic [DBITS-1:0] first_word = '0;
    logic [DBITS-1:0] last_word = '0;
    bit finished = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    m_ready   = 1'b0;
    while (!cmd_ready && guard < 100) begin
      step();
      guard++;
    end
    check({v.name, " accept"}, cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (done) dones++;
      if (m_valid && first_cyc < 0) first_cyc = cyc;
      if (stalled) check({v.name, " hold"}, {m_valid, m_last, m_data}, {1'b1, held});
      m_ready = v.rpat[cyc % 16];
      if (m_valid && m_ready) begin
        check({v.name, " data"}, m_data, ram[(v.addr + beats) % 16]);
        check({v.name, " last"}, m_last, (beats == v.exp_beats - 1));
        if (beats == 0) begin
          first_word = m_data;
          first_beat_cyc = cyc;
        end
        last_word = m_data;
        last_beat_cyc = cyc;
        beats++;
        if (m_last) finished = 1'b1;
      end
      stalled = m_valid && !m_ready;
      held = {m_last, m_data};
      step();
    end
    m_ready = 1'b0;
    check({v.name, " beats"}, beats, v.exp_beats);
    check({v.name, " first"}, first_word, v.exp_first);
    check({v.name, " lastw"}, last_word, v.exp_last);
    check({v.name, " latency"}, first_cyc, 2);
    if (v.rpat == 16'hFFFF)
      check({v.name, " nogap"}, last_beat_cyc - first_beat_cyc, v.exp_beats - 1);
    check({v.name, " early_done"}, dones, 0);
    check({v.name, " done"}, {done, busy, cmd_ready, m_valid}, 4'b1010);
    step();
    check({v.name, " done_once"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int beats;
    int early;
    for (int i = 0; i < 16; i++) ram[i] = 32'hCAFE_0000 + i;

    vecs[0] = '{name: "basic",  addr: 4'd5,  len: 5'd4, rpat: 16'hFFFF, exp_beats: 4,
                exp_first: 32'hCAFE_0005, exp_last: 32'hCAFE_0008};
    vecs[1] = '{name: "wrap",   addr: 4'd14, len: 5'd4, rpat: 16'hFFFF, exp_beats: 4,
                exp_first: 32'hCAFE_000E, exp_last: 32'hCAFE_0001};
    vecs[2] = '{name: "bp",     addr: 4'd2,  len: 5'd8, rpat: 16'h9999, exp_beats: 8,
                exp_first: 32'hCAFE_0002, exp_last: 32'hCAFE_0009};
    vecs[3] = '{name: "single", addr: 4'd15, len: 5'd1, rpat: 16'hFFFF, exp_beats: 1,
                exp_first: 32'hCAFE_000F, exp_last: 32'hCAFE_000F};
    vecs[4] = '{name: "bp_alt", addr: 4'd9,  len: 5'd5, rpat: 16'h5555, exp_beats: 5,
                exp_first: 32'hCAFE_0009, exp_last: 32'hCAFE_000D};

    // Reset values
    step();
    step();
    check("rst cmd_ready", cmd_ready, 1'b0);
    check("rst outputs", {m_valid, m_last, busy, done}, 4'b0000);
    check("rst raddr", mem_raddr, 4'd0);
    check("rst data", m_data, 32'd0);
    rst = 1'b0;
    step();
    check("post_rst cmd_ready", cmd_ready, 1'b1);

    // Hand-timed basic burst: beats in cycles T+3..T+6, done at T+7
    cmd_valid = 1'b1; cmd_addr = 4'd5; cmd_len = 5'd4; m_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("t1 busy/ready", {busy, cmd_ready, m_valid}, 3'b100);
    check("t1 raddr", mem_raddr, 4'd5);
    step();
    check("t2 m_valid", m_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("tk beat", {m_valid, m_last, m_data}, {1'b1, (k == 3), 32'hCAFE_0005 + k});
    end
    step();
    check("t7 done", {done, busy, m_valid, cmd_ready}, 4'b1001);
    step();
    check("t8 done low", done, 1'b0);
    m_ready = 1'b0;

    for (int i = 0; i < 5; i++) run_burst(vecs[i]);

    // Zero length
    cmd_valid = 1'b1; cmd_addr = 4'd7; cmd_len = 5'd0;
    step();
    cmd_valid = 1'b0;
    check("zero t1", {busy, done, m_valid, cmd_ready}, 4'b1000);
    step();
    check("zero t2", {busy, done, m_valid, cmd_ready}, 4'b0101);
    step();
    check("zero t3", {done, m_valid}, 2'b00);

    // Full memory with a second command queued behind it
    cmd_valid = 1'b1; cmd_addr = 4'd0; cmd_len = 5'd16; m_ready = 1'b1;
    step();
    cmd_addr = 4'd3; cmd_len = 5'd2;
    beats = 0;
    early = 0;
    for (int c = 0; c < 40 && beats < 16; c++) begin
      if (cmd_ready) early++;
      if (m_valid) begin
        check("full data", m_data, 32'hCAFE_0000 + beats);
        beats++;
      end
      step();
    end
    check("full beats", beats, 16);
    check("full stall", early, 0);
    check("full done", {done, cmd_ready}, 2'b11);
    step();
    cmd_valid = 1'b0;
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      if (m_valid) begin
        check("queued beat", {m_last, m_data}, {(beats == 1), 32'hCAFE_0003 + beats});
        beats++;
      end
      step();
    end
    check("queued beats", beats, 2);
    step();
    m_ready = 1'b0;

    // Reset after the second beat of a six-word burst
    cmd_valid = 1'b1; cmd_addr = 4'd0; cmd_len = 5'd6; m_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      if (m_valid) beats++;
      step();
    end
    check("abort beats", beats, 2);
    rst = 1'b1;
    step();
    check("abort state", {m_valid, busy, done}, 3'b000);
    rst = 1'b0;
    step();
    check("abort no done", {done, cmd_ready, m_valid}, 3'b010);
    m_ready = 1'b0;
    run_burst('{name: "post_abort", addr: 4'd3, len: 5'd3, rpat: 16'hFFFF, exp_beats: 3,
                exp_first: 32'hCAFE_0003, exp_last: 32'hCAFE_0005});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rl_ram_1r1w_burst_reader.md
Name: rl_ram_1r1w_burst_reader

Overview:
- Read-side engine for a 1R1W inferred RAM with one-cycle registered read latency and no read enable.
- Accepts a burst command (start address, word count) and drives the RAM read address.
- Returns the words as a valid/ready stream with back-pressure and a last-beat marker.
- Sits between the RAM read port and a downstream consumer (DMA, packet egress); the write side is owned elsewhere.

Parameters:
- ABITS, 10, RAM address width; depth is 2**ABITS words.
- DBITS, 32, RAM data width.
- LBITS, ABITS+1, burst length width; allows a burst of the full 2**ABITS words.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  burst command valid.
- cmd_ready  output  1  engine can accept a command; high only in IDLE.
- cmd_addr  input  ABITS  start word address.
- cmd_len  input  LBITS  number of words; 0 is legal.
- mem_raddr  output  ABITS  registered read address to RAM raddr.
- mem_dout  input  DBITS  RAM dout; valid one cycle after the matching mem_raddr.
- m_valid  output  1  output beat valid.
- m_ready  input  1  consumer accepts the beat.
- m_data  output  DBITS  output word.
- m_last  output  1  final beat of the burst.
- busy  output  1  high from command accept until the done pulse.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset values: cmd_ready=0 while rst is high and 1 in the first cycle after; m_valid=0, m_last=0, busy=0, done=0, mem_raddr=0, m_data=0.
- A reset mid-burst aborts the burst: buffer and in-flight flag cleared, no done pulse.
- FSM states: IDLE, ISSUE, DRAIN (state enum lives in the package).
  - IDLE -> ISSUE on cmd_valid && cmd_ready with cmd_len!=0. Latches the address, sets remaining=cmd_len and busy=1.
  - IDLE with cmd_len==0: accept the command, busy=1 for one cycle, done pulses the next cycle, no beats, return to IDLE.
  - ISSUE -> DRAIN on the cycle the final address is issued.
  - DRAIN -> IDLE on the handshake of the beat with m_last=1. done pulses in the following cycle, with busy=0 in that same cycle.
- Issue rule: an address is issued in a cycle when remaining!=0 and (occupancy + inflight - pop) < 2.
  - occupancy: output buffer entries, 0..2.
  - inflight: 1 if an address was issued last cycle.
  - pop: m_valid && m_ready.
- On issue: mem_raddr <= current address, address increments modulo 2**ABITS (wraps from 2**ABITS-1 to 0), remaining decrements.
- Data capture: one cycle after an issue, mem_dout is written into the 2-entry buffer. The RAM has no read enable, so only tracked cycles are captured. The buffer can never overflow under the issue rule; an overflow would be a design bug, guarded by an assertion.
- Output: m_valid = buffer not empty; m_data/m_last come from the head entry. m_last is tagged at issue time on the word where remaining==1.
- Latency and throughput:
  - Command accepted at edge T: mem_raddr valid in cycle T+1, first m_valid in cycle T+3.
  - With m_ready held high: one beat per cycle, no bubbles.
- Back-pressure: m_data, m_last and m_valid stay stable while m_valid && !m_ready. Issue stalls when occupancy + inflight reaches 2.
- Read/write collision: same-address write and read in one cycle returns old data. No bypass; the reader inherits RAM behaviour.
- cmd_valid outside IDLE is ignored (cmd_ready=0).

Decomposition:
- Package rl_mem_pkg: burst_state_t enum (IDLE, ISSUE, DRAIN).
- Sub-module rl_skid_fifo2: 2-entry valid/ready buffer.
  - Width parameter: DBITS+1 (data plus last).
  - Ports: push/pop, full/empty, count.
- Top level holds the FSM, address/length counters and the inflight flag.

Test Plan:
- Basic burst: RAM preloaded mem[i]=i; cmd addr=5, len=4, m_ready=1 -> beats 5,6,7,8 on consecutive cycles starting T+3; m_last on 8; done one cycle later.
- Wrap-around: ABITS=4, addr=14, len=4 -> data from addresses 14,15,0,1, no gap.
- Back-pressure: len=8, m_ready toggling 1,0,0,1,... -> all 8 words in order, none dropped or duplicated, data held stable while stalled, at most 2 issues outstanding.
- Zero length: len=0 -> cmd accepted, no m_valid, done pulses the next cycle, cmd_ready back to 1.
- Full memory: ABITS=4, len=16, addr=0 -> 16 beats; a second command stalls until done.
- Reset mid-burst: assert rst after the 2nd beat of len=6 -> next cycle m_valid=0, busy=0, no done; a new burst afterwards starts clean with correct data.
